// File: rtl/swr_pkg.sv
// ---------------------------------------------------------------------------
// swr_pkg : shared types and constants for serial_word_receiver  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package swr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Wide enough to hold a count of WIDTH received data bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/swr_hold_reg.sv
// ---------------------------------------------------------------------------
// swr_hold_reg : one-entry output register with valid/ready and overrun
// (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module swr_hold_reg
  import swr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic [WIDTH-1:0] word,
  input  logic             word_perr,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             par_err,
  output logic             overrun
);

  logic drop;

  assign drop = commit && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A consumer draining the slot on the commit edge frees it for the new word.
      if (commit && (!out_valid || out_ready)) begin
        out_data  <= word;
        par_err   <= word_perr;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver : LSB-first serial-to-parallel receiver with hold
// register; optional trailing even parity via SWR_PARITY_EN  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module serial_word_receiver
  import swr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             par_err
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SWR_PARITY_EN
  localparam int SR_W = WIDTH;
`else
  // The last data bit goes straight from sin into the committed word.
  localparam int SR_W = WIDTH - 1;
`endif

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SR_W-1:0] shreg, shreg_nxt, shreg_shifted;
  logic            commit;
  logic [WIDTH-1:0] word;
  logic            word_perr;

  assign shreg_shifted = SR_W'({sin, shreg} >> 1);

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    commit    = 1'b0;
`ifdef SWR_PARITY_EN
    word      = shreg;
    word_perr = ^{sin, shreg};
`else
    word      = {sin, shreg};
    word_perr = 1'b0;
`endif

    if (sync) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      shreg_nxt = '0;
    end else if (sin_en) begin
      case (state)
        IDLE, SHIFT: begin
          state_nxt = SHIFT;
          cnt_nxt   = cnt + CW'(1);
          shreg_nxt = shreg_shifted;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SWR_PARITY_EN
            state_nxt = PARITY;
`else
            commit    = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
            shreg_nxt = '0;
`endif
          end
        end
        PARITY: begin
          commit    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          shreg_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          shreg_nxt = '0;
        end
      endcase
    end
  end

  swr_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (CLK),
    .rst_n    (RES),
    .commit   (commit),
    .word     (word),
    .word_perr(word_perr),
    .out_ready(out_ready),
    .ovr_clr  (ovr_clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .par_err  (par_err),
    .overrun  (overrun)
  );

endmodule

`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_word_receiver : directed self-checking bench, WIDTH=4  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       sin = 1'b0;
  logic       sin_en = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overrun;
  logic       ovr_clr = 1'b0;
  logic       par_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         xfers   = 0;
  logic [3:0] xfer_log [0:15];

  serial_word_receiver #(.WIDTH(4)) dut (
    .CLK      (clk),
    .RES      (res),
    .sin      (sin),
    .sin_en   (sin_en),
    .sync     (sync),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  // Log every handshake; the negedge sees the values the next rising edge uses.
  always @(negedge clk) begin
    if (res && out_valid && out_ready) begin
      xfer_log[xfers[3:0]] = out_data;
      xfers = xfers + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin    = b;
    sin_en = 1'b1;
    @(posedge clk);
    #1;
    sin_en = 1'b0;
    sin    = 1'b0;
  endtask

  // Sends a whole word (plus its good parity bit in parity builds); ready_last
  // raises out_ready just before the word's final bit.
  task automatic send_word(input logic [3:0] w, input logic ready_last);
`ifdef SWR_PARITY_EN
    for (int i = 0; i < 4; i++) send_bit(w[i]);
    if (ready_last) out_ready = 1'b1;
    send_bit(^w);
`else
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    if (ready_last) out_ready = 1'b1;
    send_bit(w[3]);
`endif
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while RES is held low.
    #12;
    check("rst_data",    out_data,  0);
    check("rst_valid",   out_valid, 0);
    check("rst_overrun", overrun,   0);
    check("rst_parerr",  par_err,   0);
    @(posedge clk);
    #1;
    res = 1'b1;

    // Word 1,0,1,1 = 4'hD, not valid before its last bit.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("d_pre_valid", out_valid, 0);
`ifdef SWR_PARITY_EN
    send_bit(1'b1);
    check("d_pre_valid_p", out_valid, 0);
    send_bit(1'b1);
`else
    send_bit(1'b1);
`endif
    check("d_valid",   out_valid, 1);
    check("d_data",    out_data,  4'hD);
    check("d_overrun", overrun,   0);
    check("d_parerr",  par_err,   0);

    // Second word while full: dropped, overrun set, held word kept.
    send_word(4'h8, 1'b0);
    check("ovr_data",  out_data,  4'hD);
    check("ovr_valid", out_valid, 1);
    check("ovr_set",   overrun,   1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // 4'h3 held, then 4'hA commits on the same edge 4'h3 is accepted.
    drain();
    xfers = 0;
    send_word(4'h3, 1'b0);
    check("b2b_3_data", out_data, 4'h3);
    send_word(4'hA, 1'b1);
    check("b2b_valid",   out_valid, 1);
    check("b2b_a_data",  out_data,  4'hA);
    check("b2b_overrun", overrun,   0);
    check("b2b_xfer1",   xfers,     1);
    check("b2b_log0",    xfer_log[0], 4'h3);
    @(posedge clk);
    #1;
    check("b2b_xfer2",  xfers,       2);
    check("b2b_log1",   xfer_log[1], 4'hA);
    check("b2b_empty",  out_valid,   0);

    // Streaming with out_ready held high.
    send_word(4'h5, 1'b0);
    send_word(4'hC, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("str_xfers",   xfers,       4);
    check("str_log2",    xfer_log[2], 4'h5);
    check("str_log3",    xfer_log[3], 4'hC);
    check("str_overrun", overrun,     0);

    // Partial word discarded by sync (sync overrides a sampled bit).
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1; sin = 1'b1; sin_en = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0; sin = 1'b0; sin_en = 1'b0;
    check("sync_valid0", out_valid, 0);
    send_word(4'h6, 1'b0);
    check("sync_data",  out_data,  4'h6);
    check("sync_valid", out_valid, 1);

    // Asynchronous reset mid-word clears outputs without a clock edge.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    res = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data",  out_data,  0);
    check("arst_ovr",   overrun,   0);
    @(posedge clk);
    #1;
    res = 1'b1;
    send_word(4'h9, 1'b0);
    check("post_rst_data",  out_data,  4'h9);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_ovr",   overrun,   0);

`ifdef SWR_PARITY_EN
    // Data 1,1,0,0 with bad then good parity.
    drain();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("par_bad_err",  par_err,  1);
    check("par_bad_data", out_data, 4'h3);
    drain();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    check("par_ok_err",  par_err,  0);
    check("par_ok_data", out_data, 4'h3);
`else
    check("nopar_err", par_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
